network_interface: RTL and testbench
====================================

Name: network_interface

Overview:
- Local network interface (NIC) attached to the router's local port (port index NUM_PORTS-1).
- Injection side: accepts host packets (single-flit), queues them, forms flits `{dest, payload}` and injects them into the router's local input under credit control.
- Ejection side: captures flits from the router's local output into a queue drained by the host with valid/ready.

Parameters:
- NUM_ROUTERS, 16, routers in mesh
- ROUTER_ID, 0, this router's ID
- NUM_VC, 4, VCs on router local input port; equals initial injection credits
- INJ_DEPTH, 4, injection queue depth (power of 2)
- EJ_DEPTH, 8, ejection queue depth (power of 2)
- ROUTER_ID_BITS, $clog2(NUM_ROUTERS), dest field width
- PAYLOAD_BITS, `FLIT_DATA_WIDTH - ROUTER_ID_BITS`, payload width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- host_valid  in  1  host injection request
- host_ready  out  1  injection queue not full
- host_dest  in  ROUTER_ID_BITS  destination router
- host_payload  in  PAYLOAD_BITS  payload
- inj_data  out  `FLIT_DATA_WIDTH`  flit to router local input_data
- inj_valid  out  1  flit valid to router local input_valid
- inj_credit_return  in  1  one local-port VC freed (pulse)
- ej_in_data  in  `FLIT_DATA_WIDTH`  router local out_data
- ej_in_valid  in  1  router local out_valid
- ej_data  out  PAYLOAD_BITS  ejected payload
- ej_src_ok  out  1  ejected flit dest field == ROUTER_ID
- ej_valid  out  1  ejection queue head valid
- ej_ready  in  1  host consumes head
- ej_overflow  out  1  sticky: a flit was dropped on a full ejection queue
- err_credit  out  1  sticky: credit return while counter == NUM_VC
- stat_inj_count  out  16  injected flits (see optional feature)
- stat_ej_count  out  16  ejected flits (see optional feature)

Behaviour:
- Reset (reset==0 at posedge):
  - Queues emptied.
  - credits = NUM_VC.
  - Sticky flags cleared; stats counters cleared.
  - inj_valid=0, ej_valid=0, host_ready=0 for that cycle, then 1.
- Injection acceptance: host handshake on host_valid && host_ready. Flit = `{host_dest, host_payload}`, with dest in MSBs `[FLIT_DATA_WIDTH-1 -: ROUTER_ID_BITS]`.
- Injection FSM (registered inj_valid/inj_data):
  - IDLE: queue empty → stay.
  - SEND: queue non-empty and credits>0 → pop head, drive inj_valid=1 for exactly one cycle, credits-1.
  - STALL: queue non-empty and credits==0 → inj_valid=0 until credit arrives.
  - At most one flit per cycle.
  - Latency: flit accepted at cycle t into an empty queue with credits>0 appears on inj_valid at t+1.
  - Back-to-back injection allowed while credits last.
- Credit arithmetic:
  - Same-cycle inject and inj_credit_return → credits unchanged.
  - Return with credits==NUM_VC and no inject → counter holds, err_credit set.
  - Credits never underflow.
- Host side of the injection queue:
  - host_ready = !full.
  - Push and pop in the same cycle on a full queue is allowed (ready stays 0 that cycle; push refused).
- Ejection:
  - ej_in_valid at cycle t → entry written at posedge t; ej_valid=1 from t+1 if queue was empty.
  - No backpressure to the router: on full queue the incoming flit is dropped and ej_overflow set. A same-cycle pop frees the slot and the flit is kept.
- Ejected entry:
  - ej_data = payload bits.
  - ej_src_ok = (dest field == ROUTER_ID); misrouted flits are still delivered.
- Pop on ej_valid && ej_ready. ej_ready while empty is ignored.
- Reset mid-operation: all in-flight queue contents discarded, credits restored to NUM_VC.

Optional Feature:
- NI_STATS_EN defined: stat_inj_count increments on each inj_valid; stat_ej_count increments on each ejection-queue write. Both are 16-bit and saturate at 16'hFFFF.
- Not defined: both outputs tied to 0, no counter flops.

Decomposition:
- Package noc_pkg:
  - ROUTER_ID_BITS/PAYLOAD_BITS derivation from `FLIT_DATA_WIDTH`.
  - Packed flit_t typedef `{dest, payload}`.
  - Injection FSM state enum (IDLE, SEND, STALL).
- Sub-module ni_credit_counter: credits register, inc/dec, saturation, err flag. Queues reuse the existing fifo module (one per direction, reset polarity adapted locally).

Test Plan:
- Reset then inject 3 flits dest=5 payload 1,2,3 back-to-back, no credit returns → inj_valid on 3 consecutive cycles starting 1 cycle after first accept, inj_data MSBs=5; credits=1.
- Inject 6 flits, NUM_VC=4, no returns → exactly 4 inj_valid pulses, FSM in STALL. One inj_credit_return → 5th flit issues the next cycle.
- Credits=0 and queue holding 2; credit return coincident with reset=0 → after reset, queue empty, credits=4, inj_valid stays 0.
- Push 9 flits dest=ROUTER_ID into EJ_DEPTH=8 queue, ej_ready=0 → 8 stored, ej_overflow=1. Drain yields payloads in order with ej_src_ok=1.
- Ejection queue full, ej_in_valid and ej_ready same cycle → no drop, ej_overflow stays 0, occupancy stays 8.
- inj_credit_return with credits=4 and no inject → err_credit=1, credits=4. With NI_STATS_EN, stat_inj_count matches inj_valid pulse count.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC types: flit layout, injection FSM states and a saturating counter helper.
// The flit width comes from the FLIT_DATA_WIDTH macro and defaults to 32 bits.
`ifndef FLIT_DATA_WIDTH
`define FLIT_DATA_WIDTH 32
`endif

package noc_pkg;
  localparam int FLIT_W              = `FLIT_DATA_WIDTH;
  localparam int DEF_NUM_ROUTERS     = 16;
  localparam int DEF_ROUTER_ID_BITS  = $clog2(DEF_NUM_ROUTERS);
  localparam int DEF_PAYLOAD_BITS    = FLIT_W - DEF_ROUTER_ID_BITS;

  // The destination sits in the MSBs so routers can decode it without knowing the payload width.
  typedef struct packed {
    logic [DEF_ROUTER_ID_BITS-1:0] dest;
    logic [DEF_PAYLOAD_BITS-1:0]   payload;
  } flit_t;

  typedef enum logic [1:0] {IDLE, SEND, STALL} inj_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/fifo.sv
// Generic synchronous FIFO with an active-high reset; DEPTH must be a power of two.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/ni_credit_counter.sv
// Credit counter for the router's local input port: starts full, decrements on
// inject, increments on credit return, and flags returns that would exceed NUM_VC.
module ni_credit_counter #(
  parameter int NUM_VC = 4,
  parameter int CW     = $clog2(NUM_VC + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] credits,
  output logic          err
);
  always_ff @(posedge clk) begin
    if (!reset) begin
      credits <= CW'(NUM_VC);
      err     <= 1'b0;
    end else begin
      case ({inc, dec})
        2'b10: begin
          // A return on a full counter is a protocol error; hold the count.
          if (credits == CW'(NUM_VC)) err <= 1'b1;
          else                         credits <= credits + 1'b1;
        end
        2'b01: if (credits != '0) credits <= credits - 1'b1;
        default: credits <= credits;
      endcase
    end
  end
endmodule

// File: rtl/network_interface.sv
// Local-port network interface: host injection queue with credit-controlled flit issue,
// and an ejection queue drained by the host. Define NI_STATS_EN for flit statistics counters.
module network_interface
  import noc_pkg::*;
#(
  parameter int NUM_ROUTERS    = 16,
  parameter int ROUTER_ID      = 0,
  parameter int NUM_VC         = 4,
  parameter int INJ_DEPTH      = 4,
  parameter int EJ_DEPTH       = 8,
  parameter int ROUTER_ID_BITS = $clog2(NUM_ROUTERS),
  parameter int PAYLOAD_BITS   = FLIT_W - ROUTER_ID_BITS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      host_valid,
  output logic                      host_ready,
  input  logic [ROUTER_ID_BITS-1:0] host_dest,
  input  logic [PAYLOAD_BITS-1:0]   host_payload,
  output logic [FLIT_W-1:0]         inj_data,
  output logic                      inj_valid,
  input  logic                      inj_credit_return,
  input  logic [FLIT_W-1:0]         ej_in_data,
  input  logic                      ej_in_valid,
  output logic [PAYLOAD_BITS-1:0]   ej_data,
  output logic                      ej_src_ok,
  output logic                      ej_valid,
  input  logic                      ej_ready,
  output logic                      ej_overflow,
  output logic                      err_credit,
  output logic [15:0]               stat_inj_count,
  output logic [15:0]               stat_ej_count
);
  localparam int CW = $clog2(NUM_VC + 1);

  // Handshakes: a transfer happens on any cycle where valid && ready are both high
  // at the rising edge; valid never depends on ready.
  logic              ready_q;
  logic              inj_push;
  logic              inj_pop;
  logic              inj_full;
  logic              inj_empty;
  logic [FLIT_W-1:0] inj_head;
  logic [CW-1:0]     credits;
  inj_state_t        inj_state;

  logic              ej_pop;
  logic              ej_accept;
  logic              ej_full;
  logic              ej_empty;
  logic [FLIT_W-1:0] ej_head;

  always_ff @(posedge clk) begin
    ready_q <= reset;
  end

  assign host_ready = ready_q && !inj_full;
  assign inj_push   = host_valid && host_ready;
  assign inj_pop    = !inj_empty && (credits != '0);

  fifo #(.WIDTH(FLIT_W), .DEPTH(INJ_DEPTH)) u_inj_fifo (
    .clk   (clk),
    .rst   (!reset),
    .push  (inj_push),
    .pop   (inj_pop),
    .din   ({host_dest, host_payload}),
    .dout  (inj_head),
    .full  (inj_full),
    .empty (inj_empty)
  );

  ni_credit_counter #(.NUM_VC(NUM_VC), .CW(CW)) u_credit (
    .clk     (clk),
    .reset   (reset),
    .inc     (inj_credit_return),
    .dec     (inj_pop),
    .credits (credits),
    .err     (err_credit)
  );

  // SEND lasts exactly one cycle per popped flit, so inj_valid is a decode of the state flop.
  always_ff @(posedge clk) begin
    if (!reset) begin
      inj_state <= IDLE;
      inj_data  <= '0;
    end else if (inj_pop) begin
      inj_state <= SEND;
      inj_data  <= inj_head;
    end else begin
      inj_state <= inj_empty ? IDLE : STALL;
    end
  end

  assign inj_valid = (inj_state == SEND);

  assign ej_pop    = ej_ready && !ej_empty;
  assign ej_accept = ej_in_valid && (!ej_full || ej_pop);

  fifo #(.WIDTH(FLIT_W), .DEPTH(EJ_DEPTH)) u_ej_fifo (
    .clk   (clk),
    .rst   (!reset),
    .push  (ej_in_valid),
    .pop   (ej_pop),
    .din   (ej_in_data),
    .dout  (ej_head),
    .full  (ej_full),
    .empty (ej_empty)
  );

  assign ej_valid  = !ej_empty;
  assign ej_data   = ej_head[PAYLOAD_BITS-1:0];
  assign ej_src_ok = (ej_head[FLIT_W-1 -: ROUTER_ID_BITS] == ROUTER_ID_BITS'(ROUTER_ID));

  // The router cannot be back-pressured, so a flit arriving at a full queue is lost.
  always_ff @(posedge clk) begin
    if (!reset)                        ej_overflow <= 1'b0;
    else if (ej_in_valid && !ej_accept) ej_overflow <= 1'b1;
  end

`ifdef NI_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_inj_count <= '0;
      stat_ej_count  <= '0;
    end else begin
      if (inj_valid) stat_inj_count <= sat_inc16(stat_inj_count);
      if (ej_accept) stat_ej_count  <= sat_inc16(stat_ej_count);
    end
  end
`else
  assign stat_inj_count = '0;
  assign stat_ej_count  = '0;
`endif
endmodule

// File: tb/tb_network_interface.sv
// Bench for network_interface: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the injection and ejection paths.
`timescale 1ns/1ps
module tb_network_interface;
  import noc_pkg::*;

  localparam int RIB   = 4;
  localparam int PB    = FLIT_W - RIB;
  localparam int NV    = 4;
  localparam int INJ_D = 4;
  localparam int EJ_D  = 8;
  localparam int RID   = 0;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              host_valid;
  logic              host_ready;
  logic [RIB-1:0]    host_dest;
  logic [PB-1:0]     host_payload;
  logic [FLIT_W-1:0] inj_data;
  logic              inj_valid;
  logic              inj_credit_return;
  logic [FLIT_W-1:0] ej_in_data;
  logic              ej_in_valid;
  logic [PB-1:0]     ej_data;
  logic              ej_src_ok;
  logic              ej_valid;
  logic              ej_ready;
  logic              ej_overflow;
  logic              err_credit;
  logic [15:0]       stat_inj_count;
  logic [15:0]       stat_ej_count;

  int vectors;
  int miscompares;

  network_interface dut (
    .clk               (clk),
    .reset             (reset),
    .host_valid        (host_valid),
    .host_ready        (host_ready),
    .host_dest         (host_dest),
    .host_payload      (host_payload),
    .inj_data          (inj_data),
    .inj_valid         (inj_valid),
    .inj_credit_return (inj_credit_return),
    .ej_in_data        (ej_in_data),
    .ej_in_valid       (ej_in_valid),
    .ej_data           (ej_data),
    .ej_src_ok         (ej_src_ok),
    .ej_valid          (ej_valid),
    .ej_ready          (ej_ready),
    .ej_overflow       (ej_overflow),
    .err_credit        (err_credit),
    .stat_inj_count    (stat_inj_count),
    .stat_ej_count     (stat_ej_count)
  );

  // reference model / scoreboard
  logic [FLIT_W-1:0] inj_q[$];
  logic [FLIT_W-1:0] exp_q[$];
  int                m_credits;
  bit                m_inj_valid;
  logic [FLIT_W-1:0] m_inj_data;
  bit                m_err;
  bit                m_ovf;
  bit                m_ready;
  int                m_stat_inj;
  int                m_stat_ej;

  function automatic void model_step();
    bit send;
    bit accept;
    bit pop;
    bit write;
    if (!reset) begin
      inj_q.delete();
      exp_q.delete();
      m_credits   = NV;
      m_inj_valid = 0;
      m_err       = 0;
      m_ovf       = 0;
      m_ready     = 0;
      m_stat_inj  = 0;
      m_stat_ej   = 0;
      return;
    end
    if (m_inj_valid && m_stat_inj < 65535) m_stat_inj++;
    send   = (inj_q.size() > 0) && (m_credits > 0);
    accept = host_valid && m_ready && (inj_q.size() < INJ_D);
    m_inj_valid = send;
    if (send) begin
      m_inj_data = inj_q.pop_front();
      m_credits--;
    end
    if (inj_credit_return) begin
      if (m_credits == NV) m_err = 1;
      else                 m_credits++;
    end
    if (accept) inj_q.push_back({host_dest, host_payload});
    pop   = ej_ready && (exp_q.size() > 0);
    write = ej_in_valid && ((exp_q.size() < EJ_D) || pop);
    if (ej_in_valid && !write) m_ovf = 1;
    if (pop) void'(exp_q.pop_front());
    if (write) begin
      exp_q.push_back(ej_in_data);
      if (m_stat_ej < 65535) m_stat_ej++;
    end
    m_ready = 1;
  endfunction

  // driver tasks
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_idle();
    host_valid        = 1'b0;
    host_dest         = '0;
    host_payload      = '0;
    inj_credit_return = 1'b0;
    ej_in_valid       = 1'b0;
    ej_in_data        = '0;
    ej_ready          = 1'b0;
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    cycle();
  endtask

  task automatic test_reset();
    set_idle();
    reset = 1'b0;
    cycle();
    vectors++;
    if (host_ready !== 1'b0) begin miscompares++; $display("FAIL reset_host_ready: got %b want 0", host_ready); end
    vectors++;
    if (inj_valid !== 1'b0) begin miscompares++; $display("FAIL reset_inj_valid: got %b want 0", inj_valid); end
    vectors++;
    if (ej_valid !== 1'b0) begin miscompares++; $display("FAIL reset_ej_valid: got %b want 0", ej_valid); end
    vectors++;
    if (ej_overflow !== 1'b0 || err_credit !== 1'b0) begin
      miscompares++; $display("FAIL reset_sticky: got ovf=%b err=%b want 0 0", ej_overflow, err_credit);
    end
    vectors++;
    if (stat_inj_count !== 16'd0 || stat_ej_count !== 16'd0) begin
      miscompares++; $display("FAIL reset_stats: got %0d %0d want 0 0", stat_inj_count, stat_ej_count);
    end
    reset = 1'b1;
    cycle();
    vectors++;
    if (host_ready !== 1'b1) begin miscompares++; $display("FAIL reset_release_ready: got %b want 1", host_ready); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_stat;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      host_valid   = (i < 3);
      host_dest    = RIB'(5);
      host_payload = PB'(i + 1);
      cycle();
      vectors++;
      if (inj_valid !== ((i >= 1) && (i <= 3))) begin
        miscompares++; $display("FAIL b2b_valid[%0d]: got %b want %b", i, inj_valid, (i >= 1) && (i <= 3));
      end
      if (i >= 1 && i <= 3) begin
        vectors++;
        if (inj_data[FLIT_W-1 -: RIB] !== RIB'(5) || inj_data[PB-1:0] !== PB'(i)) begin
          miscompares++; $display("FAIL b2b_data[%0d]: got %h want dest 5 payload %0d", i, inj_data, i);
        end
      end
    end
    host_valid = 1'b0;
    vectors++;
    if (dut.u_credit.credits !== 3'd1) begin
      miscompares++; $display("FAIL b2b_credits: got %0d want 1", dut.u_credit.credits);
    end
`ifdef NI_STATS_EN
    exp_stat = 16'd3;
`else
    exp_stat = 16'd0;
`endif
    vectors++;
    if (stat_inj_count !== exp_stat) begin
      miscompares++; $display("FAIL b2b_stat_inj: got %0d want %0d", stat_inj_count, exp_stat);
    end
  endtask

  task automatic test_credit_stall();
    int pulses;
    do_reset();
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      host_valid   = (i < 6);
      host_dest    = RIB'(3);
      host_payload = PB'(i + 1);
      cycle();
      if (inj_valid === 1'b1) pulses++;
    end
    host_valid = 1'b0;
    vectors++;
    if (pulses != NV) begin miscompares++; $display("FAIL stall_pulses: got %0d want %0d", pulses, NV); end
    vectors++;
    if (dut.inj_state !== STALL) begin
      miscompares++; $display("FAIL stall_state: got %0d want %0d", dut.inj_state, STALL);
    end
    inj_credit_return = 1'b1;
    cycle();
    inj_credit_return = 1'b0;
    vectors++;
    if (inj_valid !== 1'b0) begin miscompares++; $display("FAIL stall_return_cycle: got %b want 0", inj_valid); end
    cycle();
    vectors++;
    if (inj_valid !== 1'b1 || inj_data[PB-1:0] !== PB'(5)) begin
      miscompares++; $display("FAIL stall_fifth_flit: got v=%b d=%h want v=1 payload 5", inj_valid, inj_data);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      host_valid   = (i < 6);
      host_dest    = RIB'(7);
      host_payload = PB'(50 + i);
      cycle();
    end
    host_valid = 1'b0;
    vectors++;
    if (dut.u_credit.credits !== 3'd0 || dut.u_inj_fifo.count !== 3'd2) begin
      miscompares++; $display("FAIL midrst_setup: got credits=%0d occ=%0d want 0 2", dut.u_credit.credits, dut.u_inj_fifo.count);
    end
    reset = 1'b0;
    inj_credit_return = 1'b1;
    cycle();
    reset = 1'b1;
    inj_credit_return = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      vectors++;
      if (inj_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_inj_valid[%0d]: got %b want 0", i, inj_valid); end
    end
    vectors++;
    if (dut.u_credit.credits !== 3'(NV) || dut.u_inj_fifo.empty !== 1'b1 || err_credit !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_state: got credits=%0d empty=%b err=%b want %0d 1 0", dut.u_credit.credits, dut.u_inj_fifo.empty, err_credit, NV);
    end
  endtask

  task automatic test_ej_overflow();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      ej_in_valid = 1'b1;
      ej_in_data  = {RIB'(RID), PB'(100 + i)};
      cycle();
    end
    ej_in_valid = 1'b0;
    vectors++;
    if (ej_overflow !== 1'b1 || dut.u_ej_fifo.count !== 4'd8) begin
      miscompares++; $display("FAIL ejovf_flag: got ovf=%b occ=%0d want 1 8", ej_overflow, dut.u_ej_fifo.count);
    end
    ej_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (ej_valid !== 1'b1 || ej_data !== PB'(100 + i) || ej_src_ok !== 1'b1 || ej_data !== exp_q[0][PB-1:0]) begin
        miscompares++; $display("FAIL ejovf_drain[%0d]: got v=%b d=%0d ok=%b want 1 %0d 1", i, ej_valid, ej_data, ej_src_ok, 100 + i);
      end
      cycle();
    end
    ej_ready = 1'b0;
    vectors++;
    if (ej_valid !== 1'b0) begin miscompares++; $display("FAIL ejovf_empty: got %b want 0", ej_valid); end
  endtask

  task automatic test_ej_full_simul();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      ej_in_valid = 1'b1;
      ej_in_data  = {RIB'(RID), PB'(200 + i)};
      cycle();
    end
    ej_in_data = {RIB'(RID), PB'(208)};
    ej_ready   = 1'b1;
    cycle();
    set_idle();
    vectors++;
    if (ej_overflow !== 1'b0 || dut.u_ej_fifo.count !== 4'd8 || ej_data !== PB'(201)) begin
      miscompares++; $display("FAIL ejsimul: got ovf=%b occ=%0d head=%0d want 0 8 201", ej_overflow, dut.u_ej_fifo.count, ej_data);
    end
  endtask

  task automatic test_err_credit();
    do_reset();
    inj_credit_return = 1'b1;
    cycle();
    inj_credit_return = 1'b0;
    vectors++;
    if (err_credit !== 1'b1 || dut.u_credit.credits !== 3'(NV)) begin
      miscompares++; $display("FAIL errcredit: got err=%b credits=%0d want 1 %0d", err_credit, dut.u_credit.credits, NV);
    end
    cycle();
    vectors++;
    if (err_credit !== 1'b1) begin miscompares++; $display("FAIL errcredit_sticky: got %b want 1", err_credit); end
  endtask

  task automatic test_random();
    logic [15:0] exp_si;
    logic [15:0] exp_se;
    do_reset();
    for (int n = 0; n < 800; n++) begin
      reset             = ($urandom_range(0, 149) != 0);
      host_valid        = 1'($urandom_range(0, 1));
      host_dest         = RIB'($urandom_range(0, 15));
      host_payload      = PB'($urandom);
      inj_credit_return = ($urandom_range(0, 3) == 0);
      ej_in_valid       = 1'($urandom_range(0, 1));
      ej_in_data        = {RIB'($urandom_range(0, 2)), PB'($urandom)};
      ej_ready          = ($urandom_range(0, 2) == 0);
      cycle();
      vectors++;
      if (host_ready !== (m_ready && (inj_q.size() < INJ_D))) begin
        miscompares++; $display("FAIL rnd_host_ready[%0d]: got %b want %b", n, host_ready, m_ready && (inj_q.size() < INJ_D));
      end
      vectors++;
      if (inj_valid !== m_inj_valid || (m_inj_valid && inj_data !== m_inj_data)) begin
        miscompares++; $display("FAIL rnd_inj[%0d]: got v=%b d=%h want v=%b d=%h", n, inj_valid, inj_data, m_inj_valid, m_inj_data);
      end
      vectors++;
      if (ej_valid !== (exp_q.size() > 0)) begin
        miscompares++; $display("FAIL rnd_ej_valid[%0d]: got %b want %b", n, ej_valid, exp_q.size() > 0);
      end else if (exp_q.size() > 0) begin
        vectors++;
        if (ej_data !== exp_q[0][PB-1:0] || ej_src_ok !== (exp_q[0][FLIT_W-1 -: RIB] == RIB'(RID))) begin
          miscompares++; $display("FAIL rnd_ej_head[%0d]: got d=%h ok=%b want d=%h", n, ej_data, ej_src_ok, exp_q[0][PB-1:0]);
        end
      end
      vectors++;
      if (ej_overflow !== m_ovf || err_credit !== m_err) begin
        miscompares++; $display("FAIL rnd_sticky[%0d]: got ovf=%b err=%b want %b %b", n, ej_overflow, err_credit, m_ovf, m_err);
      end
`ifdef NI_STATS_EN
      exp_si = 16'(m_stat_inj);
      exp_se = 16'(m_stat_ej);
`else
      exp_si = 16'd0;
      exp_se = 16'd0;
`endif
      vectors++;
      if (stat_inj_count !== exp_si || stat_ej_count !== exp_se) begin
        miscompares++; $display("FAIL rnd_stats[%0d]: got %0d %0d want %0d %0d", n, stat_inj_count, stat_ej_count, exp_si, exp_se);
      end
    end
    reset = 1'b1;
    set_idle();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    set_idle();
    test_reset();
    test_back_to_back();
    test_credit_stall();
    test_reset_mid();
    test_ej_overflow();
    test_ej_full_simul();
    test_err_credit();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
